// File: rtl/loop_stack_ctrl_pkg.sv
// Shared encodings for the bfcpu loop-return-address stack controller.
package loop_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  // Value returned on rsp_data when a POP/PEEK underflows.
  localparam int unsigned RSP_ERR_DATA = 0;

endpackage

// File: rtl/loop_stack_ctrl_if.sv
// Command/response bundle between the instruction sequencer and the loop stack.
interface loop_stack_ctrl_if #(
  parameter int unsigned i_addr_width = 16,
  parameter int unsigned sp_width     = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [i_addr_width-1:0] cmd_data;
  logic                    rsp_valid;
  logic [i_addr_width-1:0] rsp_data;
  logic                    rsp_err;
  logic                    ovf_err;
  logic                    udf_err;
  logic [sp_width-1:0]     depth;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, ovf_err, udf_err, depth
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, ovf_err, udf_err, depth
  );
endinterface

// File: rtl/loop_stack_ctrl_stack_ram.sv
// Loop stack storage: one write port, one read port with a registered read.
module stack_ram #(
  parameter int unsigned i_addr_width   = 16,
  parameter int unsigned sp_width       = 8,
  parameter int unsigned max_loop_depth = 255
) (
  input  logic                    clk,
  input  logic                    write_en,
  input  logic [sp_width-1:0]     write_addr,
  input  logic [i_addr_width-1:0] write_data,
  input  logic [sp_width-1:0]     read_addr,
  output logic [i_addr_width-1:0] read_data
);

  logic [i_addr_width-1:0] mem [max_loop_depth];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/loop_stack_ctrl.sv
// Loop-return-address stack controller: owns sp, sequences stack_ram, flags ovf/udf.
// Optional top-of-stack cache enabled by defining LOOP_STACK_TOS_CACHE_EN.
module loop_stack_ctrl
  import loop_stack_pkg::*;
#(
  parameter int unsigned i_addr_width   = 16,
  parameter int unsigned sp_width       = 8,
  parameter int unsigned max_loop_depth = 255
) (
  input logic               clk,
  input logic               rst,
  loop_stack_ctrl_if.slave  bus
);

  localparam logic [sp_width-1:0] MaxDepth = sp_width'(max_loop_depth);
  localparam logic [i_addr_width-1:0] ErrData = i_addr_width'(RSP_ERR_DATA);

  state_e                  state_q, state_d;
  logic [sp_width-1:0]     sp_q, sp_d;
  logic                    ovf_q, ovf_d, udf_q, udf_d;
  logic                    write_en;
  logic [sp_width-1:0]     read_addr;
  logic [i_addr_width-1:0] read_data;
  logic                    accept, full, empty;
  cmd_op_e                 op;

`ifdef LOOP_STACK_TOS_CACHE_EN
  logic [i_addr_width-1:0] tos_q, tos_d, rsp_data_q, rsp_data_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
`else
  logic                    udf_rsp_q, udf_rsp_d;
`endif

  assign op     = cmd_op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign full   = (sp_q == MaxDepth);
  assign empty  = (sp_q == '0);

  stack_ram #(
    .i_addr_width   (i_addr_width),
    .sp_width       (sp_width),
    .max_loop_depth (max_loop_depth)
  ) u_stack_ram (
    .clk        (clk),
    .write_en   (write_en),
    .write_addr (sp_q),
    .write_data (bus.cmd_data),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sp_q        <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`ifdef LOOP_STACK_TOS_CACHE_EN
      tos_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`else
      udf_rsp_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
`ifdef LOOP_STACK_TOS_CACHE_EN
      tos_q       <= tos_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`else
      udf_rsp_q   <= udf_rsp_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    write_en  = 1'b0;
    read_addr = empty ? '0 : sp_q - 1'b1;
`ifdef LOOP_STACK_TOS_CACHE_EN
    tos_d       = tos_q;
    rsp_data_d  = ErrData;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
`else
    udf_rsp_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_PUSH: begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                write_en = 1'b1;
                sp_d     = sp_q + 1'b1;
`ifdef LOOP_STACK_TOS_CACHE_EN
                tos_d    = bus.cmd_data;
`endif
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty) begin
                udf_d = 1'b1;
`ifdef LOOP_STACK_TOS_CACHE_EN
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
`else
                udf_rsp_d   = 1'b1;
`endif
              end else begin
`ifdef LOOP_STACK_TOS_CACHE_EN
                rsp_valid_d = 1'b1;
                rsp_data_d  = tos_q;
                if (op == OP_POP) begin
                  sp_d = sp_q - 1'b1;
                  // Refill the cache with the entry that becomes the new top.
                  if (sp_q >= sp_width'(2)) begin
                    read_addr = sp_q - 2'd2;
                    state_d   = ST_RD_WAIT;
                  end
                end
`else
                state_d = ST_RD_WAIT;
                if (op == OP_POP) begin
                  sp_d = sp_q - 1'b1;
                end
`endif
              end
            end
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
`ifdef LOOP_STACK_TOS_CACHE_EN
        tos_d   = read_data;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses are suppressed while rst is held so an in-flight read never surfaces.
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.ovf_err   = ovf_q;
    bus.udf_err   = udf_q;
    bus.depth     = sp_q;
`ifdef LOOP_STACK_TOS_CACHE_EN
    bus.rsp_valid = rsp_valid_q && !rst;
    bus.rsp_err   = rsp_err_q && !rst;
    bus.rsp_data  = rsp_data_q;
`else
    bus.rsp_valid = ((state_q == ST_RD_WAIT) || udf_rsp_q) && !rst;
    bus.rsp_err   = udf_rsp_q && !rst;
    bus.rsp_data  = (state_q == ST_RD_WAIT) ? read_data : ErrData;
`endif
  end

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// Self-checking bench for loop_stack_ctrl against a queue-based stack model.
module tb_loop_stack_ctrl;
  import loop_stack_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned SW   = 8;
  localparam int unsigned MAXD = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loop_stack_ctrl_if #(.i_addr_width(AW), .sp_width(SW)) bus ();

  loop_stack_ctrl #(
    .i_addr_width   (AW),
    .sp_width       (SW),
    .max_loop_depth (MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: stack contents plus the expectations for the cycle being observed.
  logic [AW-1:0] stk [$];
  bit            m_busy, m_ovf, m_udf, m_rv, m_re;
  logic [AW-1:0] m_rd;

  bit            obs_ready, obs_rv, obs_err, obs_ovf, obs_udf;
  logic [AW-1:0] obs_rd;
  int            obs_depth;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; drives one cycle, checks, advances the model.
  task automatic step(input bit r, input bit v, input logic [1:0] op, input logic [AW-1:0] d);
    bit            nbusy, nrv, nre;
    logic [AW-1:0] nrd;
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    obs_ready = bus.cmd_ready;
    obs_rv    = bus.rsp_valid;
    obs_err   = bus.rsp_err;
    obs_rd    = bus.rsp_data;
    obs_ovf   = bus.ovf_err;
    obs_udf   = bus.udf_err;
    obs_depth = int'(bus.depth);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv && !r));
    chk("rsp_err", 32'(bus.rsp_err), 32'(m_re && !r));
    if (m_rv && !r) chk("rsp_data", 32'(bus.rsp_data), 32'(m_rd));
    chk("depth", 32'(bus.depth), 32'(stk.size()));
    chk("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
    chk("udf_err", 32'(bus.udf_err), 32'(m_udf));

    nbusy = 1'b0;
    nrv   = 1'b0;
    nre   = 1'b0;
    nrd   = '0;
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (!m_busy && v) begin
      case (op)
        OP_PUSH: begin
          if (stk.size() < MAXD) stk.push_back(d);
          else m_ovf = 1'b1;
        end
        OP_POP, OP_PEEK: begin
          if (stk.size() == 0) begin
            m_udf = 1'b1;
            nrv   = 1'b1;
            nre   = 1'b1;
          end else begin
            nrv = 1'b1;
            nrd = stk[$];
`ifdef LOOP_STACK_TOS_CACHE_EN
            if (op == OP_POP) begin
              nbusy = (stk.size() >= 2);
              void'(stk.pop_back());
            end
`else
            nbusy = 1'b1;
            if (op == OP_POP) void'(stk.pop_back());
`endif
          end
        end
        default: ;
      endcase
    end
    m_busy = nbusy;
    m_rv   = nrv;
    m_re   = nre;
    m_rd   = nrd;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, OP_NOP, '0);
  endtask

  bit         rv;
  bit         rr;
  int         w;
  int         push_pct;
  int         cnt;
  logic [1:0] rop;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    m_busy = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    nop();
    chk("reset_depth", 32'(obs_depth), 32'd0);
    chk("reset_ready", 32'(obs_ready), 32'd1);
    chk("reset_rsp_valid", 32'(obs_rv), 32'd0);

    step(1'b0, 1'b1, OP_PUSH, 16'h0010);
    step(1'b0, 1'b1, OP_PUSH, 16'h0020);
    chk("push_ready", 32'(obs_ready), 32'd1);
    step(1'b0, 1'b1, OP_PUSH, 16'h0030);
    nop();
    chk("push3_depth", 32'(obs_depth), 32'd3);
    chk("push3_ovf", 32'(obs_ovf), 32'd0);

    step(1'b0, 1'b1, OP_PEEK, '0);
    nop();
    chk("peek_valid", 32'(obs_rv), 32'd1);
    chk("peek_data", 32'(obs_rd), 32'h0030);
    chk("peek_depth", 32'(obs_depth), 32'd3);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, OP_POP, '0);
      nop();
      chk("pop_data", 32'(obs_rd), 32'h0030 - 32'(i) * 32'h0010);
      nop();
    end
    chk("pop3_depth", 32'(obs_depth), 32'd0);

    step(1'b0, 1'b1, OP_POP, '0);
    nop();
    chk("udf_rsp_valid", 32'(obs_rv), 32'd1);
    chk("udf_rsp_err", 32'(obs_err), 32'd1);
    chk("udf_rsp_data", 32'(obs_rd), 32'd0);
    chk("udf_sticky", 32'(obs_udf), 32'd1);
    nop();
    chk("udf_depth", 32'(obs_depth), 32'd0);

    for (int i = 0; i < 255; i++) step(1'b0, 1'b1, OP_PUSH, AW'(i));
    step(1'b0, 1'b1, OP_PUSH, 16'hBEEF);
    nop();
    chk("ovf_sticky", 32'(obs_ovf), 32'd1);
    chk("full_depth", 32'(obs_depth), 32'd255);
    step(1'b0, 1'b1, OP_PEEK, '0);
    nop();
    chk("full_peek", 32'(obs_rd), 32'd254);
    nop();

    step(1'b0, 1'b1, OP_POP, '0);
    step(1'b1, 1'b0, OP_NOP, '0);
    chk("rst_in_flight_rsp", 32'(obs_rv), 32'd0);
    nop();
    chk("rst_depth", 32'(obs_depth), 32'd0);
    chk("rst_errs", 32'({obs_ovf, obs_udf}), 32'd0);
    chk("rst_ready", 32'(obs_ready), 32'd1);

`ifdef LOOP_STACK_TOS_CACHE_EN
    step(1'b0, 1'b1, OP_PUSH, 16'h0007);
    step(1'b0, 1'b1, OP_PUSH, 16'h0005);
    cnt = 0;
    step(1'b0, 1'b1, OP_PEEK, '0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b0, 1'b1, OP_PEEK, '0);
      else nop();
      if (obs_rv && obs_rd == 16'h0005) cnt++;
    end
    chk("tos_peek_burst", 32'(cnt), 32'd4);
    step(1'b0, 1'b1, OP_POP, '0);
    nop();
    step(1'b0, 1'b1, OP_PEEK, '0);
    nop();
    chk("tos_refill_peek", 32'(obs_rd), 32'h0007);
    nop();
`endif

    for (int ph = 0; ph < 6; ph++) begin
      push_pct = (ph % 2 == 0) ? 75 : 25;
      for (int c = 0; c < 700; c++) begin
        rv = ($urandom_range(0, 9) < 8);
        rr = ($urandom_range(0, 299) == 0);
        w  = int'($urandom_range(0, 99));
        if (w < push_pct) rop = OP_PUSH;
        else if (w % 3 == 0) rop = OP_POP;
        else if (w % 3 == 1) rop = OP_PEEK;
        else rop = OP_NOP;
        step(rr, rv, rop, AW'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_stack_ctrl.md
Name: loop_stack_ctrl

Overview:
- Sequences the loop-return-address stack for the bfcpu core.
- Accepts PUSH/POP/PEEK commands from the instruction sequencer (`[` pushes the loop-start PC, `]` peeks or pops it).
- Owns the stack pointer and drives one stack_ram instance (1 write port, 1-cycle registered read).
- Reports overflow and underflow instead of corrupting memory.

Parameters:
- i_addr_width, 16: width of the stored instruction address.
- sp_width, 8: stack pointer width.
- max_loop_depth, 255: maximum number of entries; must be <= 2**sp_width - 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK.
- cmd_data  in  i_addr_width  PUSH payload.
- rsp_valid  out  1  one-cycle pulse; response to POP/PEEK.
- rsp_data  out  i_addr_width  popped/peeked address; 0 on error.
- rsp_err  out  1  qualifies rsp_valid: underflow.
- ovf_err  out  1  sticky: a PUSH was rejected because the stack was full.
- udf_err  out  1  sticky: a POP or PEEK hit an empty stack.
- depth  out  sp_width  current entry count (the sp value).

Behaviour:
- Reset (rst=1 at an edge): sp=0, state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, ovf_err=0, udf_err=0.
  - Any in-flight read is discarded; no response is produced for it.
  - RAM contents are not cleared.
- sp convention: sp = count of valid entries; the top entry is at address sp-1.
- States: IDLE, RD_WAIT.
- IDLE, cmd_ready=1, on accept:
  - PUSH, sp < max_loop_depth: write_en=1, write_addr=sp, write_data=cmd_data; sp<=sp+1; stay IDLE. Back-to-back PUSH is allowed every cycle.
  - PUSH, sp == max_loop_depth: no write; ovf_err<=1; sp unchanged.
  - POP or PEEK, sp > 0: read_addr=sp-1; go to RD_WAIT. POP also does sp<=sp-1 on that edge.
  - POP or PEEK, sp == 0: next cycle rsp_valid=1, rsp_err=1, rsp_data=0; udf_err<=1; stay IDLE.
  - NOP: no effect.
- RD_WAIT, cmd_ready=0:
  - rsp_valid=1, rsp_data=RAM read_data, rsp_err=0.
  - Return to IDLE.
  - Latency: POP/PEEK response is exactly 1 cycle after accept; throughput is 1 per 2 cycles.
- read_addr is held at sp-1 (0 when sp=0) whenever no read is issued; harmless.
- sp arithmetic is sp_width unsigned and never wraps; saturation is enforced by the full/empty checks.
- write_en is never asserted in the same cycle as a read is issued, so no RAM read-during-write hazard can arise.
- PUSH immediately followed by PEEK returns the just-pushed value, because the write lands at the edge before the read edge.
- Sticky errors clear only on rst.

Optional Feature:
- Macro: LOOP_STACK_TOS_CACHE_EN.
- Defined:
  - A tos register mirrors entry sp-1.
  - PUSH sets tos<=cmd_data.
  - PEEK with sp>0 responds next cycle from tos without entering RD_WAIT; cmd_ready stays 1.
  - POP responds from tos and issues a refill read at sp-2 (when sp>=2). RD_WAIT loads tos from read_data and does not pulse rsp_valid.
  - Back-to-back PEEKs: 1 per cycle.
- Undefined: behaviour exactly as above; no tos register.

Decomposition:
- Package loop_stack_pkg holds:
  - the cmd_op encodings OP_NOP/OP_PUSH/OP_POP/OP_PEEK;
  - state encodings ST_IDLE/ST_RD_WAIT;
  - the rsp error code constant.
- One sub-module: stack_ram, instantiated as the storage with matching i_addr_width, sp_width and max_loop_depth.
- All control lives in loop_stack_ctrl.

Test Plan:
- Reset, then PUSH 0x0010, 0x0020, 0x0030 back-to-back -> depth=3, no errors, cmd_ready stays 1.
- PEEK -> after 1 cycle rsp_valid=1, rsp_data=0x0030, depth=3; then POP x3 -> rsp_data 0x0030, 0x0020, 0x0010, depth ends 0.
- POP with depth=0 -> next cycle rsp_valid=1, rsp_err=1, rsp_data=0; udf_err=1 sticky; depth stays 0.
- Push 255 entries (0..254), then PUSH 0xBEEF -> ovf_err=1, depth=255; PEEK returns 254.
- Assert rst in RD_WAIT after a POP accept -> no rsp_valid; depth=0; errors cleared; cmd_ready=1 next cycle.
- With LOOP_STACK_TOS_CACHE_EN: PUSH 0x0005, then PEEK every cycle x4 -> four consecutive rsp_valid with 0x0005; POP, then PEEK -> previous entry returned.
